// File: rtl/pll_sup_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RESET     = 3'd1,
        WAIT_LOCK = 3'd2,
        STABLE    = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } pll_sup_state_e;

    // Larger of two sizing values.
    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold 0..max_val without overflow; never less than 1.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Generic two-flop synchronizer, reset value 0.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First flop absorbs metastability, second presents a settled value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencing, lock qualification, retry and core reset release.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 74250,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       clk_74a,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       core_reset_n,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic [7:0] lock_loss_count
);

    localparam int unsigned TW = cnt_width(max2(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES));
    localparam int unsigned SW = cnt_width(LOCK_STABLE_CYCLES);

    pll_sup_state_e state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [SW-1:0]  stable_q, stable_d;
    logic [3:0]     retry_d;
    logic [7:0]     loss_d;
    logic           pll_rst_d, core_reset_n_d, ready_d, fault_d;
    logic           locked_s;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk   (clk_74a),
        .rst_n (reset_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    // Next state, counters and the outputs belonging to the state being entered.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        stable_d = stable_q;
        retry_d  = retry_count;
        loss_d   = lock_loss_count;

        if (!enable) begin
            state_d = IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = RESET;
                    timer_d = '0;
                end
                RESET: begin
                    if (timer_q >= TW'(RST_PULSE_CYCLES - 1)) begin
                        state_d = WAIT_LOCK;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d  = STABLE;
                        stable_d = SW'(1);
                    end else if (timer_q >= TW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                        retry_d = (retry_count == 4'hF) ? retry_count : retry_count + 4'd1;
                        timer_d = '0;
                        state_d = (32'(retry_d) == MAX_RETRIES) ? FAULT : RESET;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        state_d = WAIT_LOCK;
                        timer_d = '0;
                    end else if (stable_q >= SW'(LOCK_STABLE_CYCLES)) begin
                        state_d = RUN;
                    end else begin
                        stable_d = stable_q + SW'(1);
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state_d = RESET;
                        timer_d = '0;
                        retry_d = 4'd0;
                        loss_d  = (lock_loss_count == 8'hFF) ? lock_loss_count
                                                              : lock_loss_count + 8'd1;
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            endcase
        end

        // A fresh bring-up always starts with a clean retry history.
        if (state_d == IDLE) begin
            retry_d = 4'd0;
        end

        pll_rst_d      = (state_d == IDLE) || (state_d == RESET) || (state_d == FAULT);
        core_reset_n_d = (state_d == RUN);
        ready_d        = (state_d == RUN);
        fault_d        = (state_d == FAULT);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            timer_q         <= '0;
            stable_q        <= '0;
            retry_count     <= 4'd0;
            lock_loss_count <= 8'd0;
            pll_rst         <= 1'b1;
            core_reset_n    <= 1'b0;
            ready           <= 1'b0;
            fault           <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            stable_q        <= stable_d;
            retry_count     <= retry_d;
            lock_loss_count <= loss_d;
            pll_rst         <= pll_rst_d;
            core_reset_n    <= core_reset_n_d;
            ready           <= ready_d;
            fault           <= fault_d;
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench: a behavioural model predicts every cycle's outputs.
module tb_pll_lock_supervisor;

    localparam int RP = 4;
    localparam int LS = 8;
    localparam int TO = 32;
    localparam int MR = 2;

    logic       clk_74a    = 1'b0;
    logic       reset_n    = 1'b0;
    logic       enable     = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       core_reset_n;
    logic       ready;
    logic       fault;
    logic [3:0] retry_count;
    logic [7:0] lock_loss_count;

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES    (RP),
        .LOCK_STABLE_CYCLES  (LS),
        .LOCK_TIMEOUT_CYCLES (TO),
        .MAX_RETRIES         (MR)
    ) dut (
        .clk_74a         (clk_74a),
        .reset_n         (reset_n),
        .enable          (enable),
        .pll_locked      (pll_locked),
        .pll_rst         (pll_rst),
        .core_reset_n    (core_reset_n),
        .ready           (ready),
        .fault           (fault),
        .retry_count     (retry_count),
        .lock_loss_count (lock_loss_count)
    );

    always #5 clk_74a = ~clk_74a;

    typedef struct packed {
        logic       prst;
        logic       crn;
        logic       rdy;
        logic       flt;
        logic [3:0] retry;
        logic [7:0] loss;
    } obs_t;

    obs_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Model: phase of the bring-up plus plain counters.
    localparam int P_OFF = 0, P_PULSE = 1, P_WAIT = 2, P_QUAL = 3, P_RUN = 4, P_DEAD = 5;
    int   phase  = P_OFF;
    int   left   = 0;
    int   waited = 0;
    int   good   = 0;
    int   tries  = 0;
    int   losses = 0;
    logic s1 = 1'b0;
    logic s2 = 1'b0;

    function automatic obs_t model_out();
        obs_t o;
        o.prst  = (phase == P_OFF) || (phase == P_PULSE) || (phase == P_DEAD);
        o.crn   = (phase == P_RUN);
        o.rdy   = (phase == P_RUN);
        o.flt   = (phase == P_DEAD);
        o.retry = 4'(tries);
        o.loss  = 8'(losses);
        return o;
    endfunction

    task automatic model_step(input logic en, input logic ls);
        if (!en) begin
            phase = P_OFF;
            tries = 0;
        end else begin
            case (phase)
                P_OFF:   begin phase = P_PULSE; left = RP; end
                P_PULSE: begin
                    left = left - 1;
                    if (left == 0) begin phase = P_WAIT; waited = 0; end
                end
                P_WAIT:  begin
                    if (ls) begin
                        phase = P_QUAL; good = 1;
                    end else begin
                        waited = waited + 1;
                        if (waited == TO) begin
                            tries = (tries < 15) ? tries + 1 : 15;
                            if (tries == MR) phase = P_DEAD;
                            else begin phase = P_PULSE; left = RP; end
                        end
                    end
                end
                P_QUAL:  begin
                    if (!ls) begin phase = P_WAIT; waited = 0; end
                    else if (good == LS) phase = P_RUN;
                    else good = good + 1;
                end
                P_RUN:   begin
                    if (!ls) begin
                        losses = (losses < 255) ? losses + 1 : 255;
                        tries  = 0;
                        phase  = P_PULSE;
                        left   = RP;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Advance the model on every edge and queue the outputs it predicts.
    always @(posedge clk_74a) begin
        logic ls;
        if (!reset_n) begin
            phase = P_OFF; left = 0; waited = 0; good = 0; tries = 0; losses = 0;
            s1 = 1'b0; s2 = 1'b0;
        end else begin
            ls = s2;
            s2 = s1;
            s1 = pll_locked;
            model_step(enable, ls);
        end
        exp_q.push_back(model_out());
    end

    // Compare DUT outputs against the queued prediction mid-cycle.
    always @(negedge clk_74a) begin
        obs_t e;
        obs_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {pll_rst, core_reset_n, ready, fault, retry_count, lock_loss_count};
            if (reset_n) begin
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle t=%0t got rst=%b crn=%b rdy=%b flt=%b retry=%0d loss=%0d, want rst=%b crn=%b rdy=%b flt=%b retry=%0d loss=%0d",
                             $time, a.prst, a.crn, a.rdy, a.flt, a.retry, a.loss,
                             e.prst, e.crn, e.rdy, e.flt, e.retry, e.loss);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_74a);
        #1;
    endtask

    // Immediate check that outputs sit at their reset values.
    task automatic check_reset_now(input string what);
        obs_t a;
        a = {pll_rst, core_reset_n, ready, fault, retry_count, lock_loss_count};
        checks++;
        if (a !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0}) begin
            errors++;
            $display("FAIL %s got rst=%b crn=%b rdy=%b flt=%b retry=%0d loss=%0d, want rst=1 crn=0 rdy=0 flt=0 retry=0 loss=0",
                     what, a.prst, a.crn, a.rdy, a.flt, a.retry, a.loss);
        end
    endtask

    // Wait for the model to reach a phase (and qualification count if g >= 0).
    task automatic wait_phase(input int p, input int g, input int maxc, input string what);
        int k;
        k = 0;
        while (!(phase == p && (g < 0 || good == g)) && k < maxc) begin
            tick(1);
            k++;
        end
        checks++;
        if (!(phase == p && (g < 0 || good == g))) begin
            errors++;
            $display("FAIL %s got phase=%0d after %0d cycles, want phase=%0d", what, phase, k, p);
        end
    endtask

    task automatic async_reset(input string what);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_now(what);
        tick(3);
        reset_n = 1'b1;
    endtask

    initial begin
        #12;
        check_reset_now("power_on_reset");
        tick(2);

        // Clean bring-up
        reset_n = 1'b1;
        enable  = 1'b1;
        tick(10);
        pll_locked = 1'b1;
        tick(40);

        // Lock loss in RUN, then relock
        pll_locked = 1'b0;
        tick(10);
        pll_locked = 1'b1;
        tick(40);

        // Qualification glitch
        enable = 1'b0;
        tick(1);
        enable = 1'b1;
        wait_phase(P_QUAL, 3, 60, "reach_qual");
        pll_locked = 1'b0;
        tick(3);
        pll_locked = 1'b1;
        tick(30);

        // enable=0 in RUN, then timeouts to FAULT, then enable=0 in FAULT
        enable = 1'b0;
        tick(3);
        enable     = 1'b1;
        pll_locked = 1'b0;
        wait_phase(P_DEAD, -1, 200, "reach_fault");
        tick(5);
        enable = 1'b0;
        tick(3);

        // enable=0 on the RESET/WAIT_LOCK boundary cycle
        enable = 1'b1;
        tick(4);
        enable = 1'b0;
        tick(2);
        enable     = 1'b1;
        pll_locked = 1'b1;
        tick(40);

        // Async reset mid-RUN between edges
        async_reset("async_mid_run");
        tick(40);

        // Randomized enable/lock activity with occasional async resets
        for (int i = 0; i < 60; i++) begin
            pll_locked = 1'($urandom_range(0, 1));
            enable     = ($urandom_range(0, 9) != 0);
            tick($urandom_range(1, 60));
            if ($urandom_range(0, 19) == 0) async_reset("async_random");
        end

        tick(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
